// File: rtl/svc_fmt_iter.sv
// Multi-mode message formatter: streams STR / lowercase HEX / unsigned DEC as one ASCII byte per beat.
// Optional DEC path (double-dabble) is built only when SVC_FMT_ITER_DEC_EN is defined.
module svc_fmt_iter #(
  parameter int MAX_STR_LEN = 16,
  parameter int MAX_BIN_LEN = 8,
  parameter int LEN_W       = $clog2(MAX_BIN_LEN+1)
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  input  logic [MAX_STR_LEN*8-1:0] s_msg,
  input  logic [1:0]               s_mode,
  input  logic [LEN_W-1:0]         s_bin_len,
  output logic                     s_ready,
  output logic                     m_valid,
  output logic [7:0]               m_char,
  output logic                     m_last,
  input  logic                     m_ready
);
  localparam int MSG_W = MAX_STR_LEN*8;
  localparam int CUR_W = $clog2(4*MAX_STR_LEN);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BIN_LEN);

  localparam logic [1:0] IDLE = 2'd0, CONV = 2'd1, EMIT = 2'd2;
  localparam logic [1:0] K_STR = 2'd0, K_HEX = 2'd1;
`ifdef SVC_FMT_ITER_DEC_EN
  localparam logic [1:0] K_DEC = 2'd2;
  localparam int BIN_W = MAX_BIN_LEN*8;
  localparam int BIT_W = $clog2(BIN_W+1);
  localparam int NDIG  = (BIN_W*30103 + 99999) / 100000;
`endif

  logic [1:0]       state, kind, kind_in;
  logic [MSG_W-1:0] msg_q;
  logic [CUR_W-1:0] cur, nxt_cur, hi, hex_top;
  logic [LEN_W-1:0] len_c;
  logic [7:0]       nxt_char;
  logic             nz;

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  assign s_ready = rst_n && (state == IDLE);

  always_comb begin
    kind_in = K_STR;
    if (s_mode == 2'd1) kind_in = K_HEX;
    else if (s_mode == 2'd2) begin
`ifdef SVC_FMT_ITER_DEC_EN
      kind_in = K_DEC;
`else
      kind_in = K_HEX;
`endif
    end
    len_c   = (s_bin_len > MAX_LEN) ? MAX_LEN : s_bin_len;
    hex_top = CUR_W'({len_c, 1'b0}) - CUR_W'(1);
    nz      = |s_msg;
    hi      = '0;
    for (int i = 0; i < MAX_STR_LEN; i++)
      if (s_msg[8*i +: 8] != 8'h00) hi = CUR_W'(i);
  end

`ifdef SVC_FMT_ITER_DEC_EN
  logic [BIN_W-1:0]  sh_q;
  logic [4*NDIG-1:0] bcd_q, bcd_adj, bcd_nx;
  logic [BIT_W-1:0]  bits_q;
  logic [CUR_W-1:0]  msd;

  // One double-dabble step: add 3 to digits >= 5, then shift in the next binary MSB.
  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d < NDIG; d++)
      if (bcd_q[4*d +: 4] > 4'd4) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    bcd_nx = (bcd_adj << 1) | (4*NDIG)'(sh_q[BIN_W-1]);
    msd = '0;
    for (int d = 0; d < NDIG; d++)
      if (bcd_nx[4*d +: 4] != 4'd0) msd = CUR_W'(d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd_q  <= '0;
      sh_q   <= '0;
      bits_q <= '0;
    end else if (state == IDLE && s_valid) begin
      bcd_q  <= '0;
      sh_q   <= s_msg[BIN_W-1:0] << (BIN_W - 8*int'(len_c));
      bits_q <= BIT_W'({len_c, 3'b000});
    end else if (state == CONV) begin
      bcd_q  <= bcd_nx;
      sh_q   <= sh_q << 1;
      bits_q <= bits_q - BIT_W'(1);
    end
  end
`endif

  always_comb begin
    nxt_cur = cur - CUR_W'(1);
    case (kind)
      K_HEX:   nxt_char = hexc(msg_q[4*nxt_cur +: 4]);
`ifdef SVC_FMT_ITER_DEC_EN
      K_DEC:   nxt_char = 8'h30 + {4'h0, bcd_q[4*nxt_cur +: 4]};
`endif
      default: nxt_char = msg_q[8*nxt_cur +: 8];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      kind    <= K_STR;
      msg_q   <= '0;
      cur     <= '0;
      m_valid <= 1'b0;
      m_char  <= 8'h00;
      m_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (s_valid) begin
          msg_q <= s_msg;
          kind  <= kind_in;
          case (kind_in)
            K_HEX: if (len_c != '0) begin
              state   <= EMIT;
              m_valid <= 1'b1;
              m_char  <= hexc(s_msg[4*hex_top +: 4]);
              m_last  <= 1'b0;
              cur     <= hex_top;
            end
`ifdef SVC_FMT_ITER_DEC_EN
            K_DEC: if (len_c == '0) begin
              state   <= EMIT;
              m_valid <= 1'b1;
              m_char  <= 8'h30;
              m_last  <= 1'b1;
              cur     <= '0;
            end else state <= CONV;
`endif
            // An all-zero string stays in IDLE, so s_ready is back the next cycle.
            default: if (nz) begin
              state   <= EMIT;
              m_valid <= 1'b1;
              m_char  <= s_msg[8*hi +: 8];
              m_last  <= (hi == '0);
              cur     <= hi;
            end
          endcase
        end
`ifdef SVC_FMT_ITER_DEC_EN
        // Final shift also loads the MSD so m_valid lands 8*len+1 cycles after accept.
        CONV: if (bits_q == BIT_W'(1)) begin
          state   <= EMIT;
          m_valid <= 1'b1;
          m_char  <= 8'h30 + {4'h0, bcd_nx[4*msd +: 4]};
          m_last  <= (msd == '0);
          cur     <= msd;
        end
`endif
        EMIT: if (m_ready) begin
          if (m_last) begin
            state   <= IDLE;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
          end else begin
            cur    <= nxt_cur;
            m_char <= nxt_char;
            m_last <= (nxt_cur == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_svc_fmt_iter.sv
// Directed bench for svc_fmt_iter: table of messages with expected char streams plus reset/backpressure sequences.
module tb_svc_fmt_iter;
  logic         clk = 1'b0;
  logic         rst_n, s_valid, s_ready, m_valid, m_last, m_ready;
  logic [127:0] s_msg;
  logic [1:0]   s_mode;
  logic [3:0]   s_bin_len;
  logic [7:0]   m_char;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  svc_fmt_iter dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_msg(s_msg), .s_mode(s_mode),
    .s_bin_len(s_bin_len), .s_ready(s_ready), .m_valid(m_valid), .m_char(m_char),
    .m_last(m_last), .m_ready(m_ready)
  );

  typedef struct {
    logic [1:0]   mode;
    logic [3:0]   len;
    logic [127:0] msg;
    logic [255:0] exp;
    int           n;
    int           lat;
    string        name;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic send(input vec_t v);
    int k = 0;
    while (!s_ready && k < 100) begin @(negedge clk); k++; end
    s_valid = 1'b1; s_msg = v.msg; s_mode = v.mode; s_bin_len = v.len;
    @(negedge clk);
    s_valid = 1'b0; s_msg = {4{$urandom()}}; s_mode = 2'($urandom()); s_bin_len = 4'($urandom());
  endtask

  task automatic run_vec(input vec_t v);
    int lat, quiet;
    send(v);
    if (v.n == 0) begin
      check({v.name, " s_ready"}, {63'd0, s_ready}, 64'd1);
      quiet = 0;
      for (int c = 0; c < 10; c++) begin
        if (m_valid) quiet++;
        @(negedge clk);
      end
      check({v.name, " no m_valid"}, 64'(quiet), 64'd0);
    end else begin
      lat = 1;
      while (!m_valid && lat < 200) begin @(negedge clk); lat++; end
      check({v.name, " latency"}, 64'(lat), 64'(v.lat));
      for (int i = 0; i < v.n; i++) begin
        check($sformatf("%s char%0d", v.name, i), {54'd0, m_valid, m_char, m_last},
              {54'd0, 1'b1, v.exp[8*(v.n-1-i) +: 8], 1'(i == v.n-1)});
        @(negedge clk);
      end
      check({v.name, " gap"}, {62'd0, m_valid, s_ready}, 64'd1);
    end
  endtask

  initial begin
    vec_t bp;
    int got, cyc;
    logic pv, pr, pl;
    logic [7:0] pc;
    logic [55:0] t123;

    tbl.push_back('{2'd0, 4'd0, 128'("Hello"), 256'("Hello"), 5, 1, "str_hello"});
    tbl.push_back('{2'd3, 4'd0, 128'("Hello"), 256'("Hello"), 5, 1, "rsv_hello"});
    tbl.push_back('{2'd0, 4'd0, 128'h0, 256'h0, 0, 1, "str_empty"});
    tbl.push_back('{2'd0, 4'd0, 128'("A"), 256'("A"), 1, 1, "str_single"});
    tbl.push_back('{2'd0, 4'd0, 128'h610062, 256'h610062, 3, 1, "str_emb0"});
    tbl.push_back('{2'd1, 4'd8, 128'hCAFE0000BABEF00D, 256'("cafe0000babef00d"), 16, 1, "hex8"});
    tbl.push_back('{2'd1, 4'd2, 128'hCAFE, 256'("cafe"), 4, 1, "hex2"});
    tbl.push_back('{2'd1, 4'd15, 128'hCAFE, 256'("000000000000cafe"), 16, 1, "hex_clamp"});
    tbl.push_back('{2'd1, 4'd1, 128'h1234AB, 256'("ab"), 2, 1, "hex1"});
    tbl.push_back('{2'd1, 4'd0, 128'hCAFE, 256'h0, 0, 1, "hex_len0"});
`ifdef SVC_FMT_ITER_DEC_EN
    tbl.push_back('{2'd2, 4'd4, 128'hFFFF, 256'("65535"), 5, 33, "dec_65535"});
    tbl.push_back('{2'd2, 4'd4, 128'h0, 256'("0"), 1, 33, "dec_zero"});
    tbl.push_back('{2'd2, 4'd0, 128'h1234, 256'("0"), 1, 1, "dec_len0"});
    tbl.push_back('{2'd2, 4'd2, 128'hFF0100, 256'("256"), 3, 17, "dec_256"});
    tbl.push_back('{2'd2, 4'd8, {64'h1, 64'hFFFFFFFFFFFFFFFF}, 256'("18446744073709551615"), 20, 65, "dec_max"});
`else
    tbl.push_back('{2'd2, 4'd4, 128'hFFFF, 256'("0000ffff"), 8, 1, "m2_ffff"});
    tbl.push_back('{2'd2, 4'd4, 128'h0, 256'("00000000"), 8, 1, "m2_zero"});
    tbl.push_back('{2'd2, 4'd0, 128'h1234, 256'h0, 0, 1, "m2_len0"});
    tbl.push_back('{2'd2, 4'd2, 128'hFF0100, 256'("0100"), 4, 1, "m2_0100"});
`endif
    tbl.push_back('{2'd0, 4'd0, 128'("First"), 256'("First"), 5, 1, "b2b_first"});
    tbl.push_back('{2'd0, 4'd0, 128'("Second"), 256'("Second"), 6, 1, "b2b_second"});

    rst_n = 1'b0; s_valid = 1'b0; s_msg = '0; s_mode = '0; s_bin_len = '0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset outs", {53'd0, s_ready, m_valid, m_last, m_char}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post reset s_ready", {63'd0, s_ready}, 64'd1);

    foreach (tbl[i]) run_vec(tbl[i]);

    // Backpressure: m_ready high one cycle in four.
    t123 = "Test123";
    bp = '{2'd0, 4'd0, 128'("Test123"), 256'("Test123"), 7, 1, "bp"};
    m_ready = 1'b0;
    send(bp);
    got = 0; cyc = 0; pv = 1'b0; pr = 1'b0; pc = '0; pl = 1'b0;
    while (got < 7 && cyc < 100) begin
      m_ready = (cyc % 4 == 3);
      if (pv && !pr)
        check($sformatf("bp hold%0d", cyc), {54'd0, m_valid, m_char, m_last}, {54'd0, 1'b1, pc, pl});
      if (m_valid && m_ready) begin
        check($sformatf("bp char%0d", got), {55'd0, m_char, m_last},
              {55'd0, t123[8*(6-got) +: 8], 1'(got == 6)});
        got++;
      end
      pv = m_valid; pr = m_ready; pc = m_char; pl = m_last;
      @(negedge clk);
      cyc++;
    end
    check("bp count", 64'(got), 64'd7);
    m_ready = 1'b1;
    check("bp done", {62'd0, m_valid, s_ready}, 64'd1);

    // Reset in the middle of a HEX stream aborts it.
    send(tbl[5]);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst outs", {62'd0, s_ready, m_valid}, 64'd0);
    rst_n = 1'b1;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      if (m_valid) got++;
      @(negedge clk);
    end
    check("midrst no output", 64'(got), 64'd0);
    check("midrst s_ready", {63'd0, s_ready}, 64'd1);

    // Stream still works after the abort.
    run_vec(tbl[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/svc_fmt_iter.md
# svc_fmt_iter

Multi-mode formatter and character iterator: accepts one message per handshake and streams it out one ASCII byte per beat over a valid/ready channel. It generalises the plain string iterator with three modes:

- **STR**: packed string.
- **HEX**: lowercase hex dump.
- **DEC**: unsigned decimal, compile-time optional.

It also adds a per-character `m_last` marker. It sits upstream of UART/debug print sinks.

## Interface
- `MAX_STR_LEN`, 16: bytes in `s_msg` for STR mode.
- `MAX_BIN_LEN`, 8: max bytes interpreted in HEX/DEC mode. Must be ≤ `MAX_STR_LEN`.
- `LEN_W`, `$clog2(MAX_BIN_LEN+1)`: width of `s_bin_len`.
- `clk` input 1: clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `s_valid` input 1: message valid.
- `s_msg` input `MAX_STR_LEN*8`: message. Byte 0 is bits [7:0]. String literals are right-aligned, so the first char is in the highest nonzero byte.
- `s_mode` input 2: 0 STR, 1 HEX, 2 DEC, 3 reserved (treated as STR).
- `s_bin_len` input `LEN_W`: HEX/DEC byte count. Values above `MAX_BIN_LEN` clamp to `MAX_BIN_LEN`.
- `s_ready` output 1: high only in IDLE. Forced 0 while `rst_n` is low.
- `m_valid` output 1: char valid. Registered.
- `m_char` output 8: ASCII char.
- `m_last` output 1: final char of the message. Qualified by `m_valid`.
- `m_ready` input 1: downstream ready.

## Operation
- States are IDLE, CONV, EMIT.
- **Accept** occurs when `s_valid && s_ready`. On accept the block captures `s_msg`, `s_mode` and the clamped length.
- **STR mode**
  - Next state is EMIT.
  - The cursor starts at the highest nonzero byte and emits bytes down to byte 0 inclusive.
  - Embedded zero bytes below the first nonzero byte are emitted as 0x00.
  - An all-zero `s_msg` emits nothing and returns to IDLE on the next cycle.
- **HEX mode**
  - Emits 2·len chars, starting with the high nibble of byte len-1 and ending with the low nibble of byte 0.
  - Nibbles map to `0`-`9` and `a`-`f`.
  - len=0 emits nothing and returns to IDLE.
- **DEC mode**
  - Next state is CONV, which runs double-dabble over the low 8·len bits, one bit per cycle, for 8·len cycles.
  - The BCD register holds `ceil(8·MAX_BIN_LEN·log10(2))` digits; this is 20 for the defaults.
  - After CONV, EMIT outputs digits MSD first with leading zeros suppressed.
  - A value of zero emits exactly `0`.
  - len=0 emits `0`.
- **EMIT**
  - Advances on each beat where `m_valid && m_ready`.
  - On the beat carrying `m_last` the state goes to IDLE.
- **Reserved mode** (`s_mode`=3) behaves exactly as STR.

## Timing
- **Reset values**: `m_valid`=0, `m_last`=0, `m_char`=0x00, state IDLE.
- **Reset mid-operation** aborts the message. No partial output follows.
- **STR/HEX latency**: first `m_valid` is asserted in the cycle after accept.
- **DEC latency**: first `m_valid` is asserted 8·len+1 cycles after accept. For len=0 it is 1 cycle.
- **Throughput**: one char per cycle while `m_ready`=1.
- **Backpressure**: while `m_valid && !m_ready`, `m_char` and `m_last` hold stable and `m_valid` stays high.
- **Message gap**: `s_ready` rises in the cycle after the last-char handshake. This gives one idle cycle between messages.
- **Input independence**: `s_msg` may change after accept without affecting output.
- **`m_ready` during CONV** is ignored.

## Configuration
- Macro: `SVC_FMT_ITER_DEC_EN`.
- **Defined**: DEC mode, the CONV state and the BCD datapath are present.
- **Undefined**: no BCD logic is built, and `s_mode`=2 behaves exactly as HEX with the same length and latency.

## Test plan
- **STR "Hello"**: `s_msg`="Hello", `m_ready`=1.
  - Response: `H`,`e`,`l`,`l`,`o` on consecutive cycles, `m_last` only on `o`.
  - `s_ready` returns 1 cycle later.
- **Empty STR**: all-zero `s_msg`.
  - Response: no `m_valid` for 10 cycles, and `s_ready` is high again 1 cycle after accept.
- **Backpressure**: STR "Test123", with `m_ready` pulsed 1 cycle in every 4.
  - Response: each char is held stable until its handshake, in the exact order `T`,`e`,`s`,`t`,`1`,`2`,`3`.
- **HEX**: 0xCAFE0000BABEF00D, len=8.
  - Response: `cafe0000babef00d`, with `m_last` on the final `d`.
- **HEX short/clamp**: 0xCAFE, len=2 → `cafe`. Same value with len=15 → clamped to 8, giving 16 chars.
- **DEC** (macro defined):
  - 0x0000FFFF, len=4 → `65535`, with first `m_valid` 33 cycles after accept.
  - Value 0 → `0`.
  - Back-to-back STR "First" then "Second" streams both correctly.
